// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns SPI byte frames (command byte + data bytes) into
// auto-incrementing single-word register bus reads/writes, prefetching read
// data so each MISO byte is loaded before the master clocks it out.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no frame; spi_tx_data tracks the live status byte
// S_CMD   | frame open, waiting for the command byte
// S_WRITE | each received byte is written to the running address
// S_READ  | each received byte loads the prefetched word for MISO
module spi_reg_ctrl #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_active,
    input  logic [7:0]        spi_rx_data,
    input  logic              spi_rx_valid,
    output logic [7:0]        spi_tx_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_ack,
    output logic              err_overrun,
    output logic              err_underrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_WRITE = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t             state_q;
    logic               active_q;
    logic [7:0]         tx_q;
    logic               req_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [7:0]         wdata_q;
    logic               ovr_q;
    logic               unr_q;
    logic [ADDR_W-1:0]  cur_q;
    logic [7:0]         pf_buf_q;
    logic               pf_valid_q;
    // outstanding read belongs to a stale address; its data must be dropped
    logic               discard_q;
    // a read of cur_q is owed as soon as the bus goes idle
    logic               refetch_q;

    logic [7:0]         status_d;
    logic               ack_d;
    logic               bus_free_d;
    logic               ack_good_d;
    logic               serve_ok_d;
    logic [7:0]         serve_data_d;
    logic [ADDR_W-1:0]  addr_nxt_d;

    // Status byte, ack qualification and the byte a READ rx would serve.
    // An ack landing with an rx byte counts as already prefetched.
    always_comb begin
        status_d     = {4'b1010, 1'b0, req_q, unr_q, ovr_q};
        ack_d        = req_q & bus_ack;
        bus_free_d   = ~req_q | bus_ack;
        ack_good_d   = ack_d & ~we_q & ~discard_q;
        serve_ok_d   = pf_valid_q | ack_good_d;
        serve_data_d = ack_good_d ? bus_rdata : pf_buf_q;
        addr_nxt_d   = cur_q + ADDR_W'(1);
    end

    // Frame sequencer, bus master and prefetch buffer in one registered FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            active_q   <= 1'b0;
            tx_q       <= 8'hA0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            ovr_q      <= 1'b0;
            unr_q      <= 1'b0;
            cur_q      <= '0;
            pf_buf_q   <= 8'h00;
            pf_valid_q <= 1'b0;
            discard_q  <= 1'b0;
            refetch_q  <= 1'b0;
        end else begin
            active_q <= spi_active;

            // completion of whatever is outstanding, in any state
            if (ack_d) begin
                req_q     <= 1'b0;
                discard_q <= 1'b0;
            end

            if (state_q != S_IDLE && !spi_active) begin
                // frame aborted/ended: let the bus finish, but drop its data
                state_q    <= S_IDLE;
                pf_valid_q <= 1'b0;
                refetch_q  <= 1'b0;
                discard_q  <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        tx_q <= status_d;
                        if (spi_active && !active_q) begin
                            state_q <= S_CMD;
                            ovr_q   <= 1'b0;
                            unr_q   <= 1'b0;
                        end
                    end

                    S_CMD: begin
                        if (spi_rx_valid) begin
                            cur_q <= spi_rx_data[ADDR_W-1:0];
                            if (spi_rx_data[7]) begin
                                state_q <= S_READ;
                                if (bus_free_d) begin
                                    req_q     <= 1'b1;
                                    we_q      <= 1'b0;
                                    addr_q    <= spi_rx_data[ADDR_W-1:0];
                                    discard_q <= 1'b0;
                                    refetch_q <= 1'b0;
                                end else begin
                                    discard_q <= 1'b1;
                                    refetch_q <= 1'b1;
                                end
                            end else begin
                                state_q <= S_WRITE;
                            end
                        end
                    end

                    S_WRITE: begin
                        if (spi_rx_valid) begin
                            cur_q <= addr_nxt_d;
                            if (bus_free_d) begin
                                req_q   <= 1'b1;
                                we_q    <= 1'b1;
                                addr_q  <= cur_q;
                                wdata_q <= spi_rx_data;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end
                    end

                    S_READ: begin
                        if (spi_rx_valid) begin
                            tx_q       <= serve_ok_d ? serve_data_d : 8'hEE;
                            pf_valid_q <= 1'b0;
                            cur_q      <= addr_nxt_d;
                            if (!serve_ok_d) begin
                                unr_q <= 1'b1;
                            end
                            if (bus_free_d) begin
                                req_q     <= 1'b1;
                                we_q      <= 1'b0;
                                addr_q    <= addr_nxt_d;
                                discard_q <= 1'b0;
                                refetch_q <= 1'b0;
                            end else begin
                                discard_q <= 1'b1;
                                refetch_q <= 1'b1;
                            end
                        end else begin
                            if (ack_good_d) begin
                                pf_buf_q   <= bus_rdata;
                                pf_valid_q <= 1'b1;
                            end
                            // req_q low means the stale read has retired
                            if (refetch_q && !req_q) begin
                                req_q     <= 1'b1;
                                we_q      <= 1'b0;
                                addr_q    <= cur_q;
                                discard_q <= 1'b0;
                                refetch_q <= 1'b0;
                            end
                        end
                    end

                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign spi_tx_data  = tx_q;
    assign bus_req      = req_q;
    assign bus_we       = we_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;
    assign err_overrun  = ovr_q;
    assign err_underrun = unr_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed frame table, hand-written abort/reset
// sequences and randomized frames checked against a register-map model.
module tb_spi_reg_ctrl;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          spi_active;
    logic [7:0]    spi_rx_data;
    logic          spi_rx_valid;
    logic [7:0]    spi_tx_data;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [7:0]    bus_wdata;
    logic [7:0]    bus_rdata;
    logic          bus_ack;
    logic          err_overrun;
    logic          err_underrun;

    int checks   = 0;
    int failures = 0;

    int          lat = 2;
    logic [7:0]  smem [128];
    logic [14:0] wlog [$];
    int          n_req = 0;

    spi_reg_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .spi_active(spi_active),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .spi_tx_data(spi_tx_data), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .err_overrun(err_overrun), .err_underrun(err_underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Register slave: acks each request 'lat' cycles after it appears.
    initial begin : responder
        bit            busy;
        int            cnt;
        logic [AW-1:0] ca;
        logic          cw;
        logic [7:0]    cd;
        bus_ack = 1'b0; bus_rdata = 8'h00;
        busy = 1'b0; cnt = 0; ca = '0; cw = 1'b0; cd = 8'h00;
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (rst) begin
                busy = 1'b0;
            end else begin
                if (bus_req && !busy) begin
                    busy = 1'b1; cnt = lat - 1;
                    ca = bus_addr; cw = bus_we; cd = bus_wdata;
                    n_req++;
                end else if (busy) begin
                    cnt--;
                end
                if (busy && cnt <= 0) begin
                    chk("bus_stable", {15'd0, bus_req, bus_we, bus_addr, bus_wdata},
                        {15'd0, 1'b1, cw, ca, cd});
                    bus_ack = 1'b1;
                    busy = 1'b0;
                    if (cw) begin
                        smem[ca] = cd;
                        wlog.push_back({ca, cd});
                    end else begin
                        bus_rdata = smem[ca];
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        spi_rx_data = b; spi_rx_valid = 1'b1;
        @(negedge clk);
        spi_rx_valid = 1'b0;
    endtask

    task automatic wait_bus_idle(input string nm);
        int k;
        k = 0;
        while (bus_req && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(nm, {31'd0, bus_req}, 32'd0);
    endtask

    task automatic frame_begin();
        spi_active = 1'b1;
        cyc(2);
    endtask

    task automatic frame_end();
        spi_active = 1'b0;
        cyc(2);
        wait_bus_idle("frame_end_bus_idle");
        cyc(2);
    endtask

    typedef struct {
        logic [7:0]       cmd;
        int               nb;
        logic [5:0][7:0]  d;
        int               lat;
        int               gap;
        logic [7:0]       pre;
        int               ntx;
        logic [5:0][7:0]  tx;
        int               nw;
        logic [5:0][14:0] wr;
        logic             ovr;
        logic             unr;
    } vec_t;

    vec_t vt [4];

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] got [6];
        string      tg;
        tg = $sformatf("vec%0d", idx);
        lat = v.lat;
        wlog.delete();
        chk({tg, "_idle_status"}, {24'd0, spi_tx_data}, {24'd0, v.pre});
        frame_begin();
        chk({tg, "_snapshot"}, {24'd0, spi_tx_data}, {24'd0, v.pre});
        chk({tg, "_flags_cleared"}, {30'd0, err_overrun, err_underrun}, 32'd0);
        send(v.cmd);
        for (int i = 0; i < v.nb; i++) begin
            cyc(v.gap - 1);
            send(v.d[i]);
            got[i] = spi_tx_data;
        end
        cyc(v.gap);
        chk({tg, "_err_overrun"}, {31'd0, err_overrun}, {31'd0, v.ovr});
        chk({tg, "_err_underrun"}, {31'd0, err_underrun}, {31'd0, v.unr});
        frame_end();
        for (int i = 0; i < v.ntx; i++)
            chk($sformatf("%s_miso%0d", tg, i), {24'd0, got[i]}, {24'd0, v.tx[i]});
        chk({tg, "_nwrites"}, wlog.size(), v.nw);
        for (int i = 0; i < v.nw; i++)
            chk($sformatf("%s_write%0d", tg, i),
                {17'd0, (i < wlog.size()) ? wlog[i] : 15'h7FFF}, {17'd0, v.wr[i]});
    endtask

    initial begin : main
        vec_t        v;
        logic [7:0]  emem [128];
        logic [14:0] ew [$];
        logic        isr;
        int          a, n, gp, nr;
        logic [7:0]  d;

        rst = 1'b1; spi_active = 1'b0; spi_rx_data = 8'h00; spi_rx_valid = 1'b0;
        for (int k = 0; k < 128; k++) smem[k] = 8'(k + 8'h40);

        // write 0x05: 11,22,33 with 2-cycle acks
        v = '{default: '0};
        v.cmd = 8'h05; v.nb = 3; v.d[0] = 8'h11; v.d[1] = 8'h22; v.d[2] = 8'h33;
        v.lat = 2; v.gap = 6; v.pre = 8'hA0;
        v.nw = 3; v.wr[0] = {7'h05, 8'h11}; v.wr[1] = {7'h06, 8'h22}; v.wr[2] = {7'h07, 8'h33};
        vt[0] = v;
        // read 0x7E with wrap, register = addr+0x40
        v = '{default: '0};
        v.cmd = 8'hFE; v.nb = 4; v.lat = 3; v.gap = 8; v.pre = 8'hA0;
        v.ntx = 4; v.tx[0] = 8'hBE; v.tx[1] = 8'hBF; v.tx[2] = 8'h40; v.tx[3] = 8'h41;
        vt[1] = v;
        // write overrun: ack 30 cycles, bytes 20 apart -> every other byte dropped
        v = '{default: '0};
        v.cmd = 8'h10; v.nb = 5; v.lat = 30; v.gap = 20; v.pre = 8'hA0;
        v.d[0] = 8'hA1; v.d[1] = 8'hB2; v.d[2] = 8'hC3; v.d[3] = 8'hD4; v.d[4] = 8'hE5;
        v.nw = 3; v.wr[0] = {7'h10, 8'hA1}; v.wr[1] = {7'h12, 8'hC3}; v.wr[2] = {7'h14, 8'hE5};
        v.ovr = 1'b1;
        vt[2] = v;
        // read underrun: ack 50 cycles, bytes 20 apart; overrun still sticky before
        v = '{default: '0};
        v.cmd = 8'hA0; v.nb = 3; v.lat = 50; v.gap = 20; v.pre = 8'hA1;
        v.ntx = 3; v.tx[0] = 8'hEE; v.tx[1] = 8'hEE; v.tx[2] = 8'hEE;
        v.unr = 1'b1;
        vt[3] = v;

        cyc(3);
        chk("reset_tx", {24'd0, spi_tx_data}, 32'hA0);
        chk("reset_bus", {15'd0, bus_req, bus_we, bus_addr, bus_wdata}, 32'd0);
        chk("reset_flags", {30'd0, err_overrun, err_underrun}, 32'd0);
        rst = 1'b0;
        cyc(3);

        for (int i = 0; i < 4; i++) run_vec(vt[i], i);

        // underrun flag is reported once in the next header, then cleared
        chk("unr_idle_status", {24'd0, spi_tx_data}, 32'hA2);
        frame_begin();
        chk("unr_snapshot", {24'd0, spi_tx_data}, 32'hA2);
        chk("unr_cleared", {31'd0, err_underrun}, 32'd0);
        frame_end();
        chk("unr_status_after", {24'd0, spi_tx_data}, 32'hA0);

        // abort with a read outstanding
        lat = 40;
        frame_begin();
        send(8'h83);
        cyc(5);
        chk("abort_req_pending", {31'd0, bus_req}, 32'd1);
        spi_active = 1'b0;
        nr = n_req;
        cyc(3);
        chk("abort_req_held", {31'd0, bus_req}, 32'd1);
        chk("abort_idle_status", {24'd0, spi_tx_data}, 32'hA4);
        wait_bus_idle("abort_bus_idle");
        cyc(5);
        chk("abort_no_new_req", n_req, nr);
        chk("abort_status_after", {24'd0, spi_tx_data}, 32'hA0);
        lat = 2;
        frame_begin();
        send(8'h83);
        cyc(4);
        send(8'h00);
        chk("abort_next_read", {24'd0, spi_tx_data}, 32'h43);
        frame_end();

        // asynchronous reset in the middle of a write
        lat = 20;
        frame_begin();
        send(8'h30);
        cyc(2);
        send(8'h5A);
        cyc(3);
        chk("rst_pre_req", {31'd0, bus_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_tx", {24'd0, spi_tx_data}, 32'hA0);
        chk("rst_async_bus", {15'd0, bus_req, bus_we, bus_addr, bus_wdata}, 32'd0);
        chk("rst_async_flags", {30'd0, err_overrun, err_underrun}, 32'd0);
        spi_active = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        run_vec(vt[0], 4);

        // randomized frames against a register-map model
        for (int k = 0; k < 128; k++) emem[k] = smem[k];
        for (int f = 0; f < 40; f++) begin
            isr = 1'($urandom_range(0, 1));
            a   = $urandom_range(0, 127);
            n   = $urandom_range(1, 6);
            lat = $urandom_range(1, 4);
            gp  = isr ? lat + $urandom_range(0, 3) : lat + 1 + $urandom_range(0, 2);
            wlog.delete();
            ew.delete();
            chk("rnd_idle_status", {24'd0, spi_tx_data}, 32'hA0);
            frame_begin();
            send({isr, 7'(a)});
            for (int i = 0; i < n; i++) begin
                cyc(gp - 1);
                d = 8'($urandom);
                send(d);
                if (isr) begin
                    chk($sformatf("rnd%0d_read%0d", f, i), {24'd0, spi_tx_data},
                        {24'd0, emem[(a + i) % 128]});
                end else begin
                    ew.push_back({7'((a + i) % 128), d});
                    emem[(a + i) % 128] = d;
                end
            end
            cyc(gp);
            frame_end();
            chk($sformatf("rnd%0d_flags", f), {30'd0, err_overrun, err_underrun}, 32'd0);
            chk($sformatf("rnd%0d_nwrites", f), wlog.size(), ew.size());
            for (int i = 0; i < ew.size(); i++)
                chk($sformatf("rnd%0d_write%0d", f, i),
                    {17'd0, (i < wlog.size()) ? wlog[i] : 15'h7FFF}, {17'd0, ew[i]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
